// File: rtl/estacionamento_pkg.sv
// Shared definitions for the parking-lot gate and space counter: default sizing,
// gate direction encoding, and the per-cycle event classification.
package estacionamento_pkg;

   localparam int CAPACIDADE_PADRAO = 99;
   localparam int LARGURA_PADRAO    = 7;

   typedef enum logic {
      ENTRADA = 1'b0,
      SAIDA   = 1'b1
   } direcao_t;

   typedef enum logic [2:0] {
      EV_NENHUM,
      EV_ENTRADA,
      EV_SAIDA,
      EV_ERRO_CHEIO,
      EV_ERRO_VAZIO
   } evento_t;

   function automatic evento_t classificar(input logic     contar,
                                           input direcao_t direcao,
                                           input logic     estaCheio,
                                           input logic     estaVazio);
      evento_t ev;
      ev = EV_NENHUM;
      if (contar) begin
         if (direcao == ENTRADA) begin
            ev = estaCheio ? EV_ERRO_CHEIO : EV_ENTRADA;
         end else begin
            ev = estaVazio ? EV_ERRO_VAZIO : EV_SAIDA;
         end
      end
      return ev;
   endfunction

   // Elaboration-time BCD of a constant, used for the display reset value.
   function automatic logic [7:0] paraBcd(input int valor);
      return {4'(valor / 10), 4'(valor % 10)};
   endfunction

endpackage

// File: rtl/bin_para_bcd.sv
// Combinational binary to two-digit BCD converter (shift-and-add-3).
// Inputs above 99 are outside its range; the hundreds digit is discarded.
module bin_para_bcd
   import estacionamento_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic [LARGURA-1:0] bin,
   output logic [3:0]         dezena,
   output logic [3:0]         unidade
);

   logic [7:0] acc;

   always_comb begin
      acc = '0;
      for (int i = LARGURA - 1; i >= 0; i--) begin
         if (acc[3:0] >= 4'd5) begin
            acc[3:0] = acc[3:0] + 4'd3;
         end
         if (acc[7:4] >= 4'd5) begin
            acc[7:4] = acc[7:4] + 4'd3;
         end
         acc = {acc[6:0], bin[i]};
      end
   end

   assign dezena  = acc[7:4];
   assign unidade = acc[3:0];

endmodule

// File: rtl/contador_vagas.sv
// Parking-space counter: saturating occupied/free counts, full/empty flags,
// sticky error on illegal events, and a registered BCD view of free spaces.
module contador_vagas
   import estacionamento_pkg::*;
#(
   parameter int CAPACIDADE = CAPACIDADE_PADRAO,
   parameter int LARGURA    = LARGURA_PADRAO
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               contar,
   input  logic               up_down,
   input  logic               limpar_erro,
   output logic [LARGURA-1:0] ocupadas,
   output logic [LARGURA-1:0] livres,
   output logic               lotado,
   output logic               vazio,
   output logic               erro,
   output logic [3:0]         bcd_dezena,
   output logic [3:0]         bcd_unidade
);

   localparam logic [LARGURA-1:0] CAP_L   = LARGURA'(CAPACIDADE);
   localparam logic [LARGURA-1:0] UM      = LARGURA'(1);
   localparam logic [7:0]         BCD_CAP = paraBcd(CAPACIDADE);

   logic [LARGURA-1:0] ocupadas_q, ocupadas_d;
   logic [LARGURA-1:0] livres_q, livres_d;
   logic               lotado_q, lotado_d;
   logic               vazio_q, vazio_d;
   logic               erro_q, erro_d;
   logic [3:0]         dezena_q, unidade_q;
   logic [3:0]         dezenaConv, unidadeConv;
   evento_t            evento;

   assign evento = classificar(contar, direcao_t'(up_down),
                               ocupadas_q == CAP_L, ocupadas_q == '0);

   // Flags and free count derive from the next count so all four registers agree.
   always_comb begin
      ocupadas_d = ocupadas_q;
      erro_d     = erro_q;
      case (evento)
         EV_ENTRADA:    ocupadas_d = ocupadas_q + UM;
         EV_SAIDA:      ocupadas_d = ocupadas_q - UM;
         EV_ERRO_CHEIO,
         EV_ERRO_VAZIO: erro_d     = 1'b1;
         default:       ocupadas_d = ocupadas_q;
      endcase
      if (limpar_erro && evento != EV_ERRO_CHEIO && evento != EV_ERRO_VAZIO) begin
         erro_d = 1'b0;
      end
      livres_d = CAP_L - ocupadas_d;
      lotado_d = (ocupadas_d == CAP_L);
      vazio_d  = (ocupadas_d == '0);
   end

   bin_para_bcd #(
      .LARGURA(LARGURA)
   ) u_bin_para_bcd (
      .bin     (livres_q),
      .dezena  (dezenaConv),
      .unidade (unidadeConv)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         ocupadas_q <= '0;
         livres_q   <= CAP_L;
         lotado_q   <= 1'b0;
         vazio_q    <= 1'b1;
         erro_q     <= 1'b0;
         dezena_q   <= BCD_CAP[7:4];
         unidade_q  <= BCD_CAP[3:0];
      end else begin
         ocupadas_q <= ocupadas_d;
         livres_q   <= livres_d;
         lotado_q   <= lotado_d;
         vazio_q    <= vazio_d;
         erro_q     <= erro_d;
         dezena_q   <= dezenaConv;
         unidade_q  <= unidadeConv;
      end
   end

   assign ocupadas    = ocupadas_q;
   assign livres      = livres_q;
   assign lotado      = lotado_q;
   assign vazio       = vazio_q;
   assign erro        = erro_q;
   assign bcd_dezena  = dezena_q;
   assign bcd_unidade = unidade_q;

endmodule

// File: tb/tb_contador_vagas.sv
// Bench for contador_vagas: a 99-space and a 4-space instance checked every
// cycle against an arithmetic model, plus hand-computed checkpoints.
module tb_contador_vagas;

   logic       CLK = 1'b0;
   logic [1:0] reset, contar, upDown, limpar;

   logic [6:0] ocup0, livres0;
   logic [2:0] ocup1, livres1;
   logic [1:0] lotado, vazio, erro;
   logic [3:0] dez0, uni0, dez1, uni1;

   int vectors     = 0;
   int miscompares = 0;

   int cap [2] = '{99, 4};
   int expOcup [2];
   int expErro [2];
   int expBcd  [2];
   bit modelValid [2] = '{1'b0, 1'b0};
   int livresAntes;
   bit ilegal;

   always #5 CLK = ~CLK;

   contador_vagas #(.CAPACIDADE(99), .LARGURA(7)) dut99 (
      .CLK(CLK), .reset(reset[0]), .contar(contar[0]), .up_down(upDown[0]),
      .limpar_erro(limpar[0]), .ocupadas(ocup0), .livres(livres0),
      .lotado(lotado[0]), .vazio(vazio[0]), .erro(erro[0]),
      .bcd_dezena(dez0), .bcd_unidade(uni0)
   );

   contador_vagas #(.CAPACIDADE(4), .LARGURA(3)) dut4 (
      .CLK(CLK), .reset(reset[1]), .contar(contar[1]), .up_down(upDown[1]),
      .limpar_erro(limpar[1]), .ocupadas(ocup1), .livres(livres1),
      .lotado(lotado[1]), .vazio(vazio[1]), .erro(erro[1]),
      .bcd_dezena(dez1), .bcd_unidade(uni1)
   );

   // Model: occupied count with saturation, sticky error, display lagging free count by one edge.
   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         livresAntes = cap[i] - expOcup[i];
         if (reset[i] === 1'b1) begin
            expOcup[i]    = 0;
            expErro[i]    = 0;
            expBcd[i]     = cap[i];
            modelValid[i] = 1'b1;
         end else if (modelValid[i]) begin
            expBcd[i] = livresAntes;
            ilegal = contar[i] && ((!upDown[i] && expOcup[i] == cap[i]) ||
                                   (upDown[i] && expOcup[i] == 0));
            if (contar[i] && !ilegal) begin
               expOcup[i] = upDown[i] ? expOcup[i] - 1 : expOcup[i] + 1;
            end
            if (ilegal) begin
               expErro[i] = 1;
            end else if (limpar[i]) begin
               expErro[i] = 0;
            end
         end
      end
   end

   task automatic checkField(input string name, input int actual, input int required);
      vectors++;
      if (actual != required) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
      end
   endtask

   function automatic int actOcup(input int i);
      return (i == 0) ? int'(ocup0) : int'(ocup1);
   endfunction
   function automatic int actLivres(input int i);
      return (i == 0) ? int'(livres0) : int'(livres1);
   endfunction
   function automatic int actDez(input int i);
      return (i == 0) ? int'(dez0) : int'(dez1);
   endfunction
   function automatic int actUni(input int i);
      return (i == 0) ? int'(uni0) : int'(uni1);
   endfunction

   // Per-cycle comparison of every meaningful output against the model.
   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (modelValid[i]) begin
            checkField($sformatf("model%0d.ocupadas", i), actOcup(i), expOcup[i]);
            checkField($sformatf("model%0d.livres", i), actLivres(i), cap[i] - expOcup[i]);
            checkField($sformatf("model%0d.lotado", i), int'(lotado[i]), int'(expOcup[i] == cap[i]));
            checkField($sformatf("model%0d.vazio", i), int'(vazio[i]), int'(expOcup[i] == 0));
            checkField($sformatf("model%0d.erro", i), int'(erro[i]), expErro[i]);
            checkField($sformatf("model%0d.dezena", i), actDez(i), expBcd[i] / 10);
            checkField($sformatf("model%0d.unidade", i), actUni(i), expBcd[i] % 10);
         end
      end
   end

   task automatic applyStimulus(input int i, input bit r, input bit c, input bit ud, input bit lp);
      reset       = '0;
      contar      = '0;
      upDown      = '0;
      limpar      = '0;
      reset[i]    = r;
      contar[i]   = c;
      upDown[i]   = ud;
      limpar[i]   = lp;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic checkOutput(input string tag, input int i, input int occ, input int liv,
                              input int lot, input int vaz, input int err);
      checkField({tag, ".ocupadas"}, actOcup(i), occ);
      checkField({tag, ".livres"}, actLivres(i), liv);
      checkField({tag, ".lotado"}, int'(lotado[i]), lot);
      checkField({tag, ".vazio"}, int'(vazio[i]), vaz);
      checkField({tag, ".erro"}, int'(erro[i]), err);
   endtask

   task automatic checkBcd(input string tag, input int i, input int dz, input int un);
      checkField({tag, ".dezena"}, actDez(i), dz);
      checkField({tag, ".unidade"}, actUni(i), un);
   endtask

   initial begin
      reset  = 2'b11;
      contar = 2'b11;
      upDown = '0;
      limpar = '0;
      expOcup = '{0, 0};
      expErro = '{0, 0};
      expBcd  = '{0, 0};
      @(posedge CLK);
      @(negedge CLK);
      reset  = 2'b11;
      contar = '0;
      @(posedge CLK);
      @(negedge CLK);
      reset = '0;

      checkOutput("reset99", 0, 0, 99, 0, 1, 0);
      checkBcd("reset99", 0, 9, 9);
      checkOutput("reset4", 1, 0, 4, 0, 1, 0);
      checkBcd("reset4", 1, 0, 4);

      repeat (3) applyStimulus(0, 0, 1, 0, 0);
      checkOutput("tresEntradas", 0, 3, 96, 0, 0, 0);
      checkBcd("tresEntradasLag", 0, 9, 7);
      applyStimulus(0, 0, 0, 1, 0);
      checkBcd("tresEntradasBcd", 0, 9, 6);
      checkOutput("ignoraDirecao", 0, 3, 96, 0, 0, 0);

      repeat (7) applyStimulus(0, 0, 1, 0, 0);
      checkOutput("dez", 0, 10, 89, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(0, 0, 1, 0, 0);
         checkOutput($sformatf("rajada%0d", k), 0, 10 + k, 89 - k, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkBcd("rajadaBcd", 0, 8, 6);

      repeat (6) applyStimulus(0, 0, 1, 1, 0);
      checkOutput("sete", 0, 7, 92, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("resetComEvento", 0, 0, 99, 0, 1, 0);
      checkBcd("resetComEvento", 0, 9, 9);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("posReset", 0, 0, 99, 0, 1, 0);
      checkBcd("posReset", 0, 9, 9);

      for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 1, 0, 0);
      checkOutput("cheio", 1, 4, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("entradaCheio", 1, 4, 0, 1, 0, 1);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("erroPegajoso", 1, 4, 0, 1, 0, 1);
      checkBcd("cheioBcd", 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("limpaCheio", 1, 4, 0, 1, 0, 0);

      repeat (4) applyStimulus(1, 0, 1, 1, 0);
      checkOutput("esvaziado", 1, 0, 4, 0, 1, 0);
      applyStimulus(1, 0, 1, 1, 0);
      checkOutput("saidaVazio", 1, 0, 4, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("limpaVazio", 1, 0, 4, 0, 1, 0);
      applyStimulus(1, 0, 1, 1, 1);
      checkOutput("setVenceLimpa", 1, 0, 4, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("limpaFinal", 1, 0, 4, 0, 1, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("recupera", 1, 1, 3, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkBcd("recuperaBcd", 1, 0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/contador_vagas.md
CONTADOR_VAGAS -- requirements
Module: contador_vagas

Interface
REQ-001 The block SHALL have parameter CAPACIDADE, default 99, meaning the number of parking spaces (legal range 1..99).
REQ-002 The block SHALL have parameter LARGURA, default 7, meaning the bit width of the count outputs (must hold CAPACIDADE).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port contar, input, 1 bit: vehicle event strobe from the gate FSM; each high cycle is one event.
REQ-006 The block SHALL have port up_down, input, 1 bit: event direction, qualified by contar; 0 = entry (increment), 1 = exit (decrement).
REQ-007 The block SHALL have port limpar_erro, input, 1 bit: clears the sticky error flag.
REQ-008 The block SHALL have port ocupadas, output, LARGURA bits: occupied spaces, registered.
REQ-009 The block SHALL have port livres, output, LARGURA bits: free spaces (CAPACIDADE - ocupadas), registered.
REQ-010 The block SHALL have port lotado, output, 1 bit: high when ocupadas == CAPACIDADE.
REQ-011 The block SHALL have port vazio, output, 1 bit: high when ocupadas == 0.
REQ-012 The block SHALL have port erro, output, 1 bit: sticky; set by an illegal event.
REQ-013 The block SHALL have ports bcd_dezena and bcd_unidade, outputs, 4 bits each: tens and units BCD digits of livres, for the panel display.

Function
REQ-014 The block SHALL, when contar=1, up_down=0 and ocupadas < CAPACIDADE, increment ocupadas by 1 at that clock edge.
REQ-015 The block SHALL, when contar=1, up_down=1 and ocupadas > 0, decrement ocupadas by 1 at that clock edge.
REQ-016 The block SHALL, when contar=0, hold ocupadas; up_down SHALL be ignored.
REQ-017 Entry when full: the block SHALL leave ocupadas unchanged (saturate, no wrap) and set erro at the same edge.
REQ-018 Exit when empty: the block SHALL leave ocupadas unchanged (no wrap to max) and set erro at the same edge.
REQ-019 The block SHALL count every cycle on which contar is high (no edge detection); back-to-back high cycles SHALL count as separate events.
REQ-020 Latency: ocupadas, livres, lotado and vazio SHALL all reflect an event in the cycle after the edge that samples contar; all four SHALL be registered and mutually consistent in every cycle.
REQ-021 lotado and vazio SHALL be computed from the next count value, so they are never a cycle stale relative to ocupadas.
REQ-022 Display pipeline: bcd_dezena and bcd_unidade SHALL be registered from livres, one cycle after livres changes (two cycles after the event edge).
REQ-023 erro SHALL stay high until a cycle with limpar_erro=1 and no new illegal event; if both occur in the same cycle, set SHALL win.
REQ-024 An illegal event SHALL never alter ocupadas, livres, lotado or vazio.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL set: ocupadas=0, livres=CAPACIDADE, vazio=1, lotado=0, erro=0, bcd digits = BCD of CAPACIDADE.
REQ-026 Reset SHALL take priority over contar and limpar_erro in the same cycle; an event present during reset SHALL be discarded.
REQ-027 Reset asserted mid-operation SHALL return to the reset state at the next edge, with no residual display pipeline content one cycle after reset deasserts.

Structure
REQ-028 A shared package (estacionamento_pkg) SHALL hold: default CAPACIDADE, LARGURA, and the direction encoding (ENTRADA=0, SAIDA=1) that the gate FSM also uses.
REQ-029 The binary-to-BCD conversion SHALL be one combinational sub-module, bin_para_bcd (LARGURA-bit in, two 4-bit digits out), instantiated once, with output registered in contador_vagas.

Verification
REQ-030 The bench SHALL apply reset, then 3 single-cycle entries (contar=1, up_down=0) -> ocupadas=3, livres=96, vazio=0, and bcd digits 9/6 two cycles after the last event.
REQ-031 The bench SHALL use CAPACIDADE=4 and apply 5 entries -> ocupadas=4, lotado=1 after the 4th entry; the 5th sets erro=1 with ocupadas still 4.
REQ-032 From empty, the bench SHALL apply an exit (up_down=1) -> ocupadas=0, vazio=1, erro=1; then limpar_erro for 1 cycle -> erro=0.
REQ-033 The bench SHALL hold contar high for 3 consecutive cycles with up_down=0 from 10 -> ocupadas=13, and SHALL check that it never skips or wraps.
REQ-034 The bench SHALL apply limpar_erro in the same cycle as an illegal exit at empty -> erro remains 1.
REQ-035 With ocupadas=7, the bench SHALL assert reset in the same cycle as contar=1 -> ocupadas=0, livres=CAPACIDADE, and the event is not counted.
